apb_wrr_arbiter: RTL and testbench
==================================

Name: apb_wrr_arbiter

Overview:
- Shares one downstream APB completer port among M APB requesters. Arbitration is weighted round-robin and is held for the whole transfer.
- Sits in front of a single peripheral, or of one output port of the APB crossbar, when several masters target that port and need bounded-latency fairness plus a hang-protection timeout.
- Each grant is sequenced through explicit SETUP/ACCESS phases. Transfers from non-granted masters are stretched with pready low.

Parameters:
- M, 2, number of requesting APB masters (2..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8.
- WEIGHT_WIDTH, 4, bits per master weight.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; 0 disables the timeout.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset, asynchronous, active-high.
- cfg_weights  in  M*WEIGHT_WIDTH  per-master consecutive-transfer budget; master i uses bits [i*WW +: WW].
- m_apb_psel, m_apb_penable, m_apb_pwrite  in  [M]  requester control.
- m_apb_pprot  in  [M][3]; m_apb_paddr  in  [M][AW]; m_apb_pwdata  in  [M][DW]; m_apb_pstrb  in  [M][SW]  requester payload.
- m_apb_pready, m_apb_pslverr  out  [M]; m_apb_prdata  out  [M][DW]  responses to requesters.
- s_apb_psel, s_apb_penable, s_apb_pwrite  out  1; s_apb_pprot  out  3; s_apb_paddr  out  AW; s_apb_pwdata  out  DW; s_apb_pstrb  out  SW  to the completer.
- s_apb_pready, s_apb_pslverr  in  1; s_apb_prdata  in  DW  from the completer.
- arb_owner  out  $clog2(M)  current or last owner index.
- arb_busy  out  1  high in SETUP or ACCESS.
- timeout_event  out  1  single-cycle pulse when a timeout fires.

Behaviour:
- Reset (async assert, sync deassert) sets the following:
  - state=IDLE, owner=M-1, credit=0, timeout count=0.
  - All s_apb_* outputs 0.
  - arb_busy=0, timeout_event=0.
  - m_apb_pready/pslverr/prdata all 0.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE, when any m_apb_psel is high, arbitrates and goes to SETUP:
  - Owner L keeps the grant if m_apb_psel[L]=1 and credit!=0; credit is unchanged.
  - Otherwise the first requesting index after L, cyclically (L+1 .. L+M), wins; credit loads with its weight, or 1 if the weight is 0.
  - The winner's pwrite/pprot/paddr/pwdata/pstrb are captured into registers that drive the s_apb_* payload.
- SETUP: s_apb_psel=1, s_apb_penable=0. Always goes to ACCESS next cycle.
- ACCESS: s_apb_psel=1, s_apb_penable=1.
  - On s_apb_pready=1 in the same cycle:
    - m_apb_pready[owner]=1.
    - m_apb_prdata[owner]=s_apb_prdata and m_apb_pslverr[owner]=s_apb_pslverr, combinational.
    - credit decrements, saturating at 0.
    - State returns to IDLE. The s_apb_psel/penable deassert registers drop them in the next cycle.
- Latency: master psel seen in cycle T (IDLE) gives s_apb_psel at T+1, s_apb_penable at T+2, and earliest m_apb_pready at T+2. There is one IDLE cycle between back-to-back transfers.
- Non-owners see pready=0, pslverr=0, prdata=0 at all times. The owner sees those outputs at 0 except in its completion cycle.
- Payload is sampled once, at grant. Requester changes after grant are ignored; this is legal because APB masters hold payload stable.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - In the ACCESS cycle where the count equals TIMEOUT_CYCLES-1 and s_apb_pready=0:
    - m_apb_pready[owner]=1, m_apb_pslverr[owner]=1, prdata=0.
    - timeout_event=1 for that cycle; credit decrements.
    - State returns to IDLE; s_apb_psel drops the next cycle.
  - A pready arriving in the same cycle as the limit wins: normal completion, no timeout.
- Weights are sampled only at new-owner grant. Changing cfg_weights mid-burst affects the next reload only.
- Reset mid-transfer aborts immediately: outputs go to reset values and no response is returned to the requester.
- arb_owner tracks the owner register. arb_busy = (state!=IDLE).

Test Plan:
- Single master 0 reads addr 0x100, completer returns 0xDEADBEEF with 0 wait states → s_apb_psel at T+1, penable at T+2, m_apb_pready[0]=1 and prdata[0]=0xDEADBEEF at T+2, other masters see 0.
- M=2, weights 2/1, both masters request continuously → grant order 0,0,1,0,0,1; non-owner pready stays 0 until its turn.
- Weight 0 on master 1 with both requesting → behaves as weight 1; order alternates correctly with master 0's budget.
- Completer inserts 5 wait states with pslverr=1 → owner pready is high only in the 6th ACCESS cycle, pslverr=1, no timeout_event.
- TIMEOUT_CYCLES=8, completer never responds → 8th ACCESS cycle gives m_apb_pready=1, pslverr=1, prdata=0, timeout_event pulses once; the next requester is granted afterwards.
- Assert preset during ACCESS → all outputs 0 immediately; after release, master 0 wins first arbitration (owner reset to M-1).

Source files
------------

// File: rtl/apb_wrr_arbiter.sv
// apb_wrr_arbiter: shares one downstream APB completer among M requesters.
// Arbitration is weighted round-robin. Each grant runs its own SETUP and ACCESS
// phases, and an optional ACCESS-phase timeout returns an error response.
module apb_wrr_arbiter #(
  parameter int M              = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int OW            = (M > 1) ? $clog2(M) : 1
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [M*WEIGHT_WIDTH-1:0]  cfg_weights,
  input  logic [M-1:0]               m_apb_psel,
  input  logic [M-1:0]               m_apb_penable,
  input  logic [M-1:0]               m_apb_pwrite,
  input  logic [M*3-1:0]             m_apb_pprot,
  input  logic [M*ADDR_WIDTH-1:0]    m_apb_paddr,
  input  logic [M*DATA_WIDTH-1:0]    m_apb_pwdata,
  input  logic [M*STRB_WIDTH-1:0]    m_apb_pstrb,
  output logic [M-1:0]               m_apb_pready,
  output logic [M-1:0]               m_apb_pslverr,
  output logic [M*DATA_WIDTH-1:0]    m_apb_prdata,
  output logic                       s_apb_psel,
  output logic                       s_apb_penable,
  output logic                       s_apb_pwrite,
  output logic [2:0]                 s_apb_pprot,
  output logic [ADDR_WIDTH-1:0]      s_apb_paddr,
  output logic [DATA_WIDTH-1:0]      s_apb_pwdata,
  output logic [STRB_WIDTH-1:0]      s_apb_pstrb,
  input  logic                       s_apb_pready,
  input  logic                       s_apb_pslverr,
  input  logic [DATA_WIDTH-1:0]      s_apb_prdata,
  output logic [OW-1:0]              arb_owner,
  output logic                       arb_busy,
  output logic                       timeout_event
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIMIT = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [WEIGHT_WIDTH-1:0] WONE = WEIGHT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                   state_q, state_d;
  logic [OW-1:0]            owner_q;
  logic [WEIGHT_WIDTH-1:0]  credit_q;
  logic [TW-1:0]            tcount_q;

  logic                     pwrite_q;
  logic [2:0]               pprot_q;
  logic [ADDR_WIDTH-1:0]    paddr_q;
  logic [DATA_WIDTH-1:0]    pwdata_q;
  logic [STRB_WIDTH-1:0]    pstrb_q;

  logic                     req_any;
  logic                     keep;
  logic [OW-1:0]            winner;
  logic [OW-1:0]            cand;
  logic [WEIGHT_WIDTH-1:0]  win_weight;
  logic [WEIGHT_WIDTH-1:0]  load_credit;
  logic                     xfer_done;
  logic                     xfer_tmo;
  logic                     finish;

  // Requester penable carries no information here: grants and phases follow psel alone.
  logic unused_penable;
  assign unused_penable = ^m_apb_penable;

  assign xfer_done = (state_q == ACCESS) && s_apb_pready;
  assign xfer_tmo  = (TIMEOUT_CYCLES > 0) && (state_q == ACCESS) && !s_apb_pready
                     && (tcount_q == TLIMIT);
  assign finish    = xfer_done || xfer_tmo;

  // Pick the winner: the owner keeps the grant while it has credit, else scan cyclically from owner+1.
  always_comb begin
    req_any = |m_apb_psel;
    keep    = m_apb_psel[owner_q] && (credit_q != '0);
    winner  = owner_q;
    cand    = owner_q;
    if (!keep) begin
      for (int k = M; k >= 1; k--) begin
        cand = OW'((int'(owner_q) + k) % M);
        if (m_apb_psel[cand]) winner = cand;
      end
    end
    win_weight  = cfg_weights[int'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    load_credit = (win_weight == '0) ? WONE : win_weight;
  end

  // State register for the IDLE/SETUP/ACCESS sequencer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one SETUP cycle per grant, then ACCESS until a response or a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner, credit and timeout bookkeeping, plus the payload captured once at grant.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      owner_q  <= OW'(M - 1);
      credit_q <= '0;
      tcount_q <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            owner_q  <= winner;
            if (!keep) credit_q <= load_credit;
            pwrite_q <= m_apb_pwrite[winner];
            pprot_q  <= m_apb_pprot[int'(winner)*3 +: 3];
            paddr_q  <= m_apb_paddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_q <= m_apb_pwdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            pstrb_q  <= m_apb_pstrb[int'(winner)*STRB_WIDTH +: STRB_WIDTH];
          end
        end
        SETUP: tcount_q <= '0;
        ACCESS: begin
          if (finish) begin
            if (credit_q != '0) credit_q <= credit_q - WONE;
          end else begin
            tcount_q <= tcount_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Route the completion (or the timeout error) back to the owner only; everyone else sees zeros.
  always_comb begin
    m_apb_pready  = '0;
    m_apb_pslverr = '0;
    m_apb_prdata  = '0;
    timeout_event = 1'b0;
    if (xfer_done) begin
      m_apb_pready[owner_q]  = 1'b1;
      m_apb_pslverr[owner_q] = s_apb_pslverr;
      m_apb_prdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] = s_apb_prdata;
    end else if (xfer_tmo) begin
      m_apb_pready[owner_q]  = 1'b1;
      m_apb_pslverr[owner_q] = 1'b1;
      timeout_event          = 1'b1;
    end
  end

  assign s_apb_psel    = (state_q != IDLE);
  assign s_apb_penable = (state_q == ACCESS);
  assign s_apb_pwrite  = pwrite_q;
  assign s_apb_pprot   = pprot_q;
  assign s_apb_paddr   = paddr_q;
  assign s_apb_pwdata  = pwdata_q;
  assign s_apb_pstrb   = pstrb_q;
  assign arb_owner     = owner_q;
  assign arb_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_wrr_arbiter.sv
// tb_apb_wrr_arbiter: directed cycle-by-cycle vectors for apb_wrr_arbiter with M=2, timeout of 8.
module tb_apb_wrr_arbiter;

  localparam int M  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int WW = 4;

  logic              pclk;
  logic              preset;
  logic [M*WW-1:0]   cfg_weights;
  logic [M-1:0]      m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [M*3-1:0]    m_apb_pprot;
  logic [M*AW-1:0]   m_apb_paddr;
  logic [M*DW-1:0]   m_apb_pwdata;
  logic [M*SW-1:0]   m_apb_pstrb;
  logic [M-1:0]      m_apb_pready, m_apb_pslverr;
  logic [M*DW-1:0]   m_apb_prdata;
  logic              s_apb_psel, s_apb_penable, s_apb_pwrite;
  logic [2:0]        s_apb_pprot;
  logic [AW-1:0]     s_apb_paddr;
  logic [DW-1:0]     s_apb_pwdata;
  logic [SW-1:0]     s_apb_pstrb;
  logic              s_apb_pready, s_apb_pslverr;
  logic [DW-1:0]     s_apb_prdata;
  logic [0:0]        arb_owner;
  logic              arb_busy, timeout_event;

  int checks = 0;
  int errors = 0;

  apb_wrr_arbiter #(
    .M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .preset(preset), .cfg_weights(cfg_weights),
    .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
    .m_apb_pprot(m_apb_pprot), .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata),
    .m_apb_pstrb(m_apb_pstrb), .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr),
    .m_apb_prdata(m_apb_prdata), .s_apb_psel(s_apb_psel), .s_apb_penable(s_apb_penable),
    .s_apb_pwrite(s_apb_pwrite), .s_apb_pprot(s_apb_pprot), .s_apb_paddr(s_apb_paddr),
    .s_apb_pwdata(s_apb_pwdata), .s_apb_pstrb(s_apb_pstrb), .s_apb_pready(s_apb_pready),
    .s_apb_pslverr(s_apb_pslverr), .s_apb_prdata(s_apb_prdata), .arb_owner(arb_owner),
    .arb_busy(arb_busy), .timeout_event(timeout_event)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    bit          do_rst;
    logic [7:0]  weights;
    logic [1:0]  psel;
    logic        spr;
    logic [31:0] rdata;
    logic        e_spsel;
    logic        e_spen;
    logic [31:0] e_paddr;
    logic        e_pwrite;
    logic [1:0]  e_mpready;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_owner;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [7:0] w, logic [1:0] psel, logic spr,
                              logic [31:0] rdata, logic spsel, logic spen, logic [31:0] paddr,
                              logic pwrite, logic [1:0] mpr, logic [31:0] rd0, logic [31:0] rd1,
                              logic own, logic busy);
    vec_t v;
    v.do_rst = rst; v.weights = w; v.psel = psel; v.spr = spr; v.rdata = rdata;
    v.e_spsel = spsel; v.e_spen = spen; v.e_paddr = paddr; v.e_pwrite = pwrite;
    v.e_mpready = mpr; v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_owner = own; v.e_busy = busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic doReset();
    preset        = 1'b1;
    m_apb_psel    = '0;
    s_apb_pready  = 1'b0;
    s_apb_pslverr = 1'b0;
    s_apb_prdata  = '0;
    @(posedge pclk);
    #1;
    preset = 1'b0;
  endtask

  task automatic drive(input logic [1:0] psel, input logic spr, input logic sperr,
                       input logic [31:0] rdata);
    m_apb_psel    = psel;
    s_apb_pready  = spr;
    s_apb_pslverr = sperr;
    s_apb_prdata  = rdata;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.do_rst) doReset();
    cfg_weights = v.weights;
    drive(v.psel, v.spr, 1'b0, v.rdata);
    checkOutput($sformatf("v%0d s_psel", idx), 32'(s_apb_psel), 32'(v.e_spsel));
    checkOutput($sformatf("v%0d s_penable", idx), 32'(s_apb_penable), 32'(v.e_spen));
    checkOutput($sformatf("v%0d s_paddr", idx), s_apb_paddr, v.e_paddr);
    checkOutput($sformatf("v%0d s_pwrite", idx), 32'(s_apb_pwrite), 32'(v.e_pwrite));
    checkOutput($sformatf("v%0d m_pready", idx), 32'(m_apb_pready), 32'(v.e_mpready));
    checkOutput($sformatf("v%0d m_pslverr", idx), 32'(m_apb_pslverr), 32'd0);
    checkOutput($sformatf("v%0d prdata0", idx), m_apb_prdata[31:0], v.e_rd0);
    checkOutput($sformatf("v%0d prdata1", idx), m_apb_prdata[63:32], v.e_rd1);
    checkOutput($sformatf("v%0d owner", idx), 32'(arb_owner), 32'(v.e_owner));
    checkOutput($sformatf("v%0d busy", idx), 32'(arb_busy), 32'(v.e_busy));
    checkOutput($sformatf("v%0d tmo", idx), 32'(timeout_event), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] r;
    preset        = 1'b1;
    cfg_weights   = '0;
    m_apb_psel    = '0;
    m_apb_penable = '0;
    m_apb_pwrite  = 2'b10;
    m_apb_pprot   = {3'b001, 3'b010};
    m_apb_paddr   = {32'h0000_0200, 32'h0000_0100};
    m_apb_pwdata  = {32'hA5A5_A5A5, 32'h1111_1111};
    m_apb_pstrb   = {4'h3, 4'hF};
    s_apb_pready  = 1'b0;
    s_apb_pslverr = 1'b0;
    s_apb_prdata  = '0;

    // Single master 0 read of 0x100, zero wait states.
    tbl.push_back(mk(1, 8'h12, 2'b01, 1, 32'hDEADBEEF, 0, 0, 32'h0,   0, 2'b00, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 8'h12, 2'b01, 1, 32'hDEADBEEF, 1, 0, 32'h100, 0, 2'b00, 32'h0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 8'h12, 2'b01, 1, 32'hDEADBEEF, 1, 1, 32'h100, 0, 2'b01, 32'hDEADBEEF, 32'h0, 0, 1));
    tbl.push_back(mk(0, 8'h12, 2'b00, 1, 32'hDEADBEEF, 0, 0, 32'h100, 0, 2'b00, 32'h0, 32'h0, 0, 0));
    // Weights 2/1, both requesting: grant order 0,0,1,0,0,1.
    r = 32'h1234_5678;
    tbl.push_back(mk(1, 8'h12, 2'b11, 1, r, 0, 0, 32'h0,   0, 2'b00, 0, 0, 1, 0));
    for (int g = 0; g < 6; g++) begin
      logic        o;
      logic [31:0] a;
      o = (g % 3 == 2);
      a = o ? 32'h200 : 32'h100;
      tbl.push_back(mk(0, 8'h12, 2'b11, 1, r, 1, 0, a, o, 2'b00, 0, 0, o, 1));
      tbl.push_back(mk(0, 8'h12, 2'b11, 1, r, 1, 1, a, o, o ? 2'b10 : 2'b01,
                       o ? 32'h0 : r, o ? r : 32'h0, o, 1));
      if (g < 5)
        tbl.push_back(mk(0, 8'h12, 2'b11, 1, r, 0, 0, a, o, 2'b00, 0, 0, o, 0));
    end
    #2;
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

    // Weight 0 on master 1 behaves as weight 1: strict alternation with master 0 weight 1.
    doReset();
    cfg_weights = 8'h01;
    for (int g = 0; g < 4; g++) begin
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput($sformatf("w0 g%0d owner", g), 32'(arb_owner), 32'(g % 2));
      tick();
      checkOutput($sformatf("w0 g%0d m_pready", g), 32'(m_apb_pready), 32'(1 << (g % 2)));
      tick();
    end

    // Five wait states with pslverr: response only in the sixth ACCESS cycle.
    doReset();
    cfg_weights = 8'h11;
    drive(2'b01, 1'b0, 1'b1, 32'h0BAD_F00D);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, (i == 5), 1'b1, 32'h0BAD_F00D);
      checkOutput($sformatf("ws%0d penable", i), 32'(s_apb_penable), 32'd1);
      checkOutput($sformatf("ws%0d m_pready", i), 32'(m_apb_pready), (i == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ws%0d m_pslverr", i), 32'(m_apb_pslverr), (i == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ws%0d prdata0", i), m_apb_prdata[31:0], (i == 5) ? 32'h0BAD_F00D : 32'h0);
      checkOutput($sformatf("ws%0d tmo", i), 32'(timeout_event), 32'd0);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("ws busy after", 32'(arb_busy), 32'd0);

    // Completer never answers: the eighth ACCESS cycle times out, then master 1 is served.
    doReset();
    cfg_weights = 8'h11;
    drive(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF);
    tick();
    checkOutput("to setup owner", 32'(arb_owner), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF);
      checkOutput($sformatf("to%0d m_pready", i), 32'(m_apb_pready), (i == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("to%0d m_pslverr", i), 32'(m_apb_pslverr), (i == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("to%0d prdata0", i), m_apb_prdata[31:0], 32'h0);
      checkOutput($sformatf("to%0d tmo", i), 32'(timeout_event), (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    checkOutput("to idle tmo", 32'(timeout_event), 32'd0);
    checkOutput("to idle busy", 32'(arb_busy), 32'd0);
    tick();
    checkOutput("to next owner", 32'(arb_owner), 32'd1);
    checkOutput("to next pwdata", s_apb_pwdata, 32'hA5A5_A5A5);
    checkOutput("to next pstrb", 32'(s_apb_pstrb), 32'h3);
    checkOutput("to next pprot", 32'(s_apb_pprot), 32'h1);
    tick();
    // pready arriving exactly at the limit cycle is a normal completion.
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, (i == 7), 1'b0, 32'hCAFE_F00D);
      checkOutput($sformatf("lim%0d m_pready", i), 32'(m_apb_pready), (i == 7) ? 32'd2 : 32'd0);
      checkOutput($sformatf("lim%0d m_pslverr", i), 32'(m_apb_pslverr), 32'd0);
      checkOutput($sformatf("lim%0d prdata1", i), m_apb_prdata[63:32], (i == 7) ? 32'hCAFE_F00D : 32'h0);
      checkOutput($sformatf("lim%0d tmo", i), 32'(timeout_event), 32'd0);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    tick();

    // Reset during ACCESS aborts at once; master 0 then wins the first arbitration.
    doReset();
    cfg_weights = 8'h11;
    drive(2'b11, 1'b1, 1'b0, 32'h5555_5555);
    tick();
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h5555_5555);
    checkOutput("rst pre m_pready", 32'(m_apb_pready), 32'd1);
    preset = 1'b1;
    #1;
    checkOutput("rst s_psel", 32'(s_apb_psel), 32'd0);
    checkOutput("rst s_penable", 32'(s_apb_penable), 32'd0);
    checkOutput("rst s_paddr", s_apb_paddr, 32'h0);
    checkOutput("rst m_pready", 32'(m_apb_pready), 32'd0);
    checkOutput("rst prdata0", m_apb_prdata[31:0], 32'h0);
    checkOutput("rst busy", 32'(arb_busy), 32'd0);
    checkOutput("rst owner", 32'(arb_owner), 32'd1);
    @(posedge pclk);
    #1;
    preset = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 32'h5555_5555);
    tick();
    checkOutput("rst after owner", 32'(arb_owner), 32'd0);
    checkOutput("rst after busy", 32'(arb_busy), 32'd1);
    tick();
    checkOutput("rst after m_pready", 32'(m_apb_pready), 32'd1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
